// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS definitions: symbol width, control tokens, clock-lane
// pattern generator and the serializer transmit-state enumeration.
package dvi_pkg;

    localparam int TMDS_WORD_W = 10;

    localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } tx_state_t;

    // Clock-lane word: word_w/2 ones then zeros, laid out in transmit order.
    // Returned in a wide container; callers slice the low word_w bits.
    function automatic logic [63:0] clk_pattern(input int word_w, input bit lsb_first);
        logic [63:0] pat;
        pat = '0;
        for (int t = 0; t < 64; t++) begin
            if (t < word_w / 2) begin
                if (lsb_first) pat[t] = 1'b1;
                else           pat[word_w - 1 - t] = 1'b1;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/tmds_word_fifo.sv
// Synchronous single-clock word FIFO with occupancy output. Pushes on full
// and pops on empty are ignored.
module tmds_word_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array: data only, never reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tmds_serializer_fifo.sv
// Bit-clock-domain TMDS serializer fed by a word FIFO. Words are loaded on
// word boundaries only, idle/underrun symbols are substituted when no data
// is due, and a free-running clock lane stays aligned with the data lanes.
module tmds_serializer_fifo
    import dvi_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int WORD_W       = 10,
    parameter int BITS_PER_CLK = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PRIME_LEVEL  = 2,
    parameter int LSB_FIRST    = 1,
    parameter logic [WORD_W-1:0] IDLE_WORD = CTRL_00
) (
    input  logic                              clk_pixel_x10,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHANNELS*WORD_W-1:0]        in_data,
    output logic [CHANNELS*BITS_PER_CLK-1:0]  tmds,
    output logic [BITS_PER_CLK-1:0]           tmds_clock,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              underrun,
    input  logic                              underrun_clr
);

    localparam int P     = WORD_W / BITS_PER_CLK;
    localparam int PH_W  = (P > 1) ? $clog2(P) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LW    = CHANNELS * WORD_W;
    localparam logic [PH_W-1:0]   PH_LAST      = PH_W'(P - 1);
    localparam logic [63:0]       CLK_PAT_FULL = clk_pattern(WORD_W, LSB_FIRST != 0);
    localparam logic [WORD_W-1:0] CLK_WORD     = CLK_PAT_FULL[WORD_W-1:0];

    logic [PH_W-1:0]                  r_phase;
    tx_state_t                        r_state;
    tx_state_t                        w_state_nxt;
    logic                             w_load;
    logic                             w_pop;
    logic                             w_push;
    logic                             w_set_underrun;
    logic                             w_full;
    logic                             w_empty;
    logic [LVL_W-1:0]                 w_level;
    logic [LW-1:0]                    w_head;
    logic [LW-1:0]                    w_sel_word;
    logic [LW-1:0]                    r_shift;
    logic [WORD_W-1:0]                r_clk_shift;
    logic [CHANNELS*BITS_PER_CLK-1:0] r_tmds;
    logic [BITS_PER_CLK-1:0]          r_tmds_clock;
    logic                             r_underrun;

    // Bits leaving the shift register this cycle; index 0 is the earlier bit.
    function automatic logic [BITS_PER_CLK-1:0] lead_bits(input logic [WORD_W-1:0] w);
        logic [BITS_PER_CLK-1:0] b;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            b[i] = (LSB_FIRST != 0) ? w[i] : w[WORD_W-1-i];
        end
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w);
        return (LSB_FIRST != 0) ? (w >> BITS_PER_CLK) : (w << BITS_PER_CLK);
    endfunction

    assign w_load     = (r_phase == PH_LAST);
    assign in_ready   = !w_full && !reset;
    assign w_push     = in_valid && in_ready;
    assign w_sel_word = w_pop ? w_head : {CHANNELS{IDLE_WORD}};
    assign tmds       = r_tmds;
    assign tmds_clock = r_tmds_clock;
    assign fifo_level = w_level;
    assign underrun   = r_underrun;

    tmds_word_fifo #(
        .WIDTH (LW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_pixel_x10),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Free-running word phase; wraps every P cycles regardless of state.
    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) r_phase <= '0;
        else       r_phase <= w_load ? '0 : r_phase + 1'b1;
    end

    // Transmit-state register.
    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, pop decision and underrun detection; FIFO traffic only moves on loads.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_set_underrun = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = PRIME;
            end
            PRIME: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_load && !w_empty && (w_level >= LVL_W'(PRIME_LEVEL))) begin
                    w_pop       = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_load) begin
                    if (!enable)      w_state_nxt    = IDLE;
                    else if (!w_empty) w_pop         = 1'b1;
                    else              w_set_underrun = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane and clock shift registers plus output registers. Reset preloads the
    // idle symbol and clock pattern so output restarts cleanly at phase 0.
    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            r_shift      <= {CHANNELS{IDLE_WORD}};
            r_clk_shift  <= CLK_WORD;
            r_tmds       <= '0;
            r_tmds_clock <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_tmds[c*BITS_PER_CLK +: BITS_PER_CLK] <= lead_bits(r_shift[c*WORD_W +: WORD_W]);
            end
            r_tmds_clock <= lead_bits(r_clk_shift);
            if (w_load) begin
                r_shift     <= w_sel_word;
                r_clk_shift <= CLK_WORD;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_shift[c*WORD_W +: WORD_W] <= shift_word(r_shift[c*WORD_W +: WORD_W]);
                end
                r_clk_shift <= shift_word(r_clk_shift);
            end
        end
    end

    // Sticky underrun flag; a new underrun wins over a same-cycle clear.
    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset)               r_underrun <= 1'b0;
        else if (w_set_underrun) r_underrun <= 1'b1;
        else if (underrun_clr)   r_underrun <= 1'b0;
    end

endmodule

// File: tb/tb_tmds_serializer_fifo.sv
`timescale 1ns/1ps
module tb_tmds_serializer_fifo;

    localparam logic [9:0]  IDLE_W = 10'b1101010100;
    localparam logic [29:0] IDLE3  = {3{IDLE_W}};
    localparam logic [9:0]  CLK_W  = 10'b0000011111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [29:0] in_data = '0;
    logic        underrun_clr = 1'b0;
    logic        in_ready;
    logic [2:0]  tmds;
    logic [0:0]  tmds_clock;
    logic [2:0]  fifo_level;
    logic        underrun;

    logic        enable2 = 1'b0;
    logic        valid2 = 1'b0;
    logic [29:0] data2 = '0;
    logic        clr2 = 1'b0;
    logic        ready2;
    logic [5:0]  tmds2;
    logic [1:0]  tmds_clock2;
    logic [2:0]  level2;
    logic        und2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tmds_serializer_fifo u_dut (
        .clk_pixel_x10 (clk),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .tmds          (tmds),
        .tmds_clock    (tmds_clock),
        .fifo_level    (fifo_level),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    tmds_serializer_fifo #(.BITS_PER_CLK(2)) u_dut2 (
        .clk_pixel_x10 (clk),
        .reset         (reset),
        .enable        (enable2),
        .in_valid      (valid2),
        .in_ready      (ready2),
        .in_data       (data2),
        .tmds          (tmds2),
        .tmds_clock    (tmds_clock2),
        .fifo_level    (level2),
        .underrun      (und2),
        .underrun_clr  (clr2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue, a symbol being sent bit by bit, and a mode.
    logic [29:0] m_q[$];
    logic [29:0] m_sym;
    logic [29:0] m_next;
    logic [2:0]  m_tmds;
    logic        m_clk;
    logic        m_und;
    bit          m_live = 0;
    bit          m_load;
    int          m_phase, m_mode, m_p, m_sz;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_sym   = IDLE3;
            m_phase = 0;
            m_mode  = 0;
            m_und   = 1'b0;
            m_live  = 1;
        end else if (m_live) begin
            m_p    = m_phase;
            m_load = (m_p == 9);
            m_sz   = m_q.size();
            m_next = IDLE3;
            for (int l = 0; l < 3; l++) m_tmds[l] = m_sym[l*10 + m_p];
            m_clk = (m_p < 5);
            case (m_mode)
                0: if (enable) m_mode = 1;
                1: begin
                    if (!enable) m_mode = 0;
                    else if (m_load && m_sz >= 2) begin
                        m_next = m_q.pop_front();
                        m_mode = 2;
                    end
                end
                default: begin
                    if (m_load) begin
                        if (!enable) m_mode = 0;
                        else if (m_sz > 0) m_next = m_q.pop_front();
                        else m_und = 1'b1;
                    end
                end
            endcase
            if (!(m_load && m_mode == 2 && enable && m_sz == 0) && underrun_clr) m_und = 1'b0;
            if (in_valid && m_sz < 4) m_q.push_back(in_data);
            if (m_load) m_sym = m_next;
            m_phase = (m_p + 1) % 10;
        end
        #1;
        if (!reset && m_live) begin
            chk("tmds", {29'd0, tmds}, {29'd0, m_tmds});
            chk("tmds_clock", {31'd0, tmds_clock}, {31'd0, m_clk});
            chk("fifo_level", {29'd0, fifo_level}, 32'(m_q.size()));
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < 4)});
            chk("underrun", {31'd0, underrun}, {31'd0, m_und});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample10(output logic [29:0] lanes, output logic [9:0] ck);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) lanes[l*10 + k] = tmds[l];
            ck[k] = tmds_clock[0];
        end
    endtask

    task automatic wait_sym_start(output bit ok);
        logic prev;
        ok = 0;
        prev = tmds_clock[0];
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (tmds_clock[0] && !prev) ok = 1;
            prev = tmds_clock[0];
        end
        if (!ok) chk("sym_align", {31'd0, ok}, 32'd1);
    endtask

    task automatic capture_sym(output logic [29:0] lanes, output logic [9:0] ck);
        bit ok;
        logic [29:0] rest_l;
        logic [9:0]  rest_c;
        wait_sym_start(ok);
        lanes = '0;
        ck = '0;
        for (int l = 0; l < 3; l++) lanes[l*10] = tmds[l];
        ck[0] = tmds_clock[0];
        rest_l = '0;
        rest_c = '0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) rest_l[l*10 + k] = tmds[l];
            rest_c[k] = tmds_clock[0];
        end
        lanes = lanes | rest_l;
        ck = ck | rest_c;
    endtask

    task automatic push_word(input logic [29:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] lanes;
        logic [9:0]  ck;
        logic [2:0]  lvl;
        bit          ok;
        bit          found;
        logic [1:0]  prev2;
        logic [9:0]  ck2;
        logic [29:0] d2;

        tick(3);
        chk("rst_tmds", {29'd0, tmds}, 32'd0);
        chk("rst_clk", {31'd0, tmds_clock}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        reset = 1'b0;

        sample10(lanes, ck);
        chk("idle_lanes", lanes, IDLE3);
        chk("idle_clk", {22'd0, ck}, {22'd0, CLK_W});

        enable = 1'b1;
        push_word(30'h3FFFFFFF);
        push_word(30'h00000000);
        lanes = IDLE3;
        for (int s = 0; s < 8 && lanes == IDLE3; s++) capture_sym(lanes, ck);
        chk("word_ones", lanes, 30'h3FFFFFFF);
        chk("word_ones_clk", {22'd0, ck}, {22'd0, CLK_W});
        capture_sym(lanes, ck);
        chk("word_zeros", lanes, 30'h0);
        capture_sym(lanes, ck);
        chk("underrun_idle", lanes, IDLE3);
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("underrun_clr", {31'd0, underrun}, 32'd0);

        enable = 1'b0;
        tick(12);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 30'($urandom);
            @(negedge clk);
        end
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 30'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;

        wait_sym_start(ok);
        tick(3);
        enable = 1'b0;
        lvl = fifo_level;
        tick(25);
        chk("retain_level", {29'd0, fifo_level}, {29'd0, lvl});
        chk("retain_nonzero", {31'd0, (lvl != 3'd0)}, 32'd1);
        capture_sym(lanes, ck);
        chk("stop_idle", lanes, IDLE3);

        wait_sym_start(ok);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tmds", {29'd0, tmds}, 32'd0);
        chk("arst_clk", {31'd0, tmds_clock}, 32'd0);
        chk("arst_level", {29'd0, fifo_level}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        tick(2);
        reset = 1'b0;
        sample10(lanes, ck);
        chk("restart_lanes", lanes, IDLE3);
        chk("restart_clk", {22'd0, ck}, {22'd0, CLK_W});

        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom % 2) == 0;
            in_data      = 30'($urandom);
            enable       = ($urandom % 40) != 0;
            underrun_clr = ($urandom % 16) == 0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        enable = 1'b0;
        underrun_clr = 1'b0;
        tick(12);

        chk("dut2_ready", {31'd0, ready2}, 32'd1);
        enable2 = 1'b1;
        valid2  = 1'b1;
        data2   = {3{10'h2AA}};
        tick(2);
        valid2 = 1'b0;
        found = 0;
        prev2 = tmds_clock2;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (tmds_clock2 == 2'b11 && prev2 == 2'b00 && tmds2[1:0] == 2'b10) found = 1;
            else prev2 = tmds_clock2;
        end
        chk("dut2_found", {31'd0, found}, 32'd1);
        ck2 = '0;
        d2 = '0;
        ck2[1:0] = tmds_clock2;
        d2[5:0] = tmds2;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            ck2[k*2 +: 2] = tmds_clock2;
            d2[k*6 +: 6] = tmds2;
        end
        chk("dut2_clk", {22'd0, ck2}, {22'd0, 10'b0000011111});
        chk("dut2_data", d2, {5{6'b101010}});
        tick(12);
        chk("dut2_underrun", {31'd0, und2}, 32'd1);
        chk("dut2_level", {29'd0, level2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
